inst_sequencer: RTL

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// inst_sequencer: 4-state instruction sequencer (FETCH/DECODE/EXEC/HALT).
// Fetches one instruction per handshake, decodes it into active-low register
// loads and an ALU source select, and maintains a registered carry flag.
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   reset_n    - asynchronous active-low reset
//   fetch_ack  - instr valid for the current fetch request
//   instr      - {opcode[3:0], immediate[DATA_W-1:0]}
//   alu_carry  - ALU carry-out, sampled in EXEC
//   fetch_req  - high while in FETCH
//   load_n     - active-low loads: [0]=A [1]=B [2]=OUT [3]=PC, pulsed in EXEC
//   select     - ALU source: 00=A 01=B 10=IN 11=zero
//   imm        - latched immediate of the current instruction
//   carry_n    - registered carry flag, active-low
//   halted     - high while in HALT
module inst_sequencer #(
  parameter int DATA_W  = 4,
  parameter int EXT_OPS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_ack,
  input  logic [DATA_W+3:0] instr,
  input  logic              alu_carry,
  output logic              fetch_req,
  output logic [3:0]        load_n,
  output logic [1:0]        select,
  output logic [DATA_W-1:0] imm,
  output logic              carry_n,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;

  // 1010 is unassigned in every configuration, so it decodes as NOP.
  localparam logic [3:0] OP_NOP  = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1100;
  localparam bit         EXT     = (EXT_OPS != 0);

  state_t     state;
  logic [3:0] op;

  // {load_n, select}. cn is the flag from before this instruction executes,
  // which is what conditional jumps test.
  function automatic logic [5:0] decode(input logic [3:0] o, input logic cn);
    logic [5:0] d;
    d = {4'b1111, 2'b11};
    case (o)
      4'b0000: d = {4'b1110, 2'b00};
      4'b0001: d = {4'b1110, 2'b01};
      4'b0010: d = {4'b1110, 2'b10};
      4'b0011: d = {4'b1110, 2'b11};
      4'b0100: d = {4'b1101, 2'b00};
      4'b0101: d = {4'b1101, 2'b01};
      4'b0110: d = {4'b1101, 2'b10};
      4'b0111: d = {4'b1101, 2'b11};
      4'b1001: d = {4'b1011, 2'b01};
      4'b1011: d = {4'b1011, 2'b11};
      4'b1111: d = {4'b0111, 2'b11};
      4'b1110: d = {(cn ? 4'b0111 : 4'b1111), 2'b11};
      4'b1100: if (EXT) d = {(!cn ? 4'b0111 : 4'b1111), 2'b11};
      default: d = {4'b1111, 2'b11};
    endcase
    return d;
  endfunction

  function automatic logic is_nop(input logic [3:0] o);
    case (o)
      4'b1010, 4'b1101: return 1'b1;
      4'b1000, 4'b1100: return !EXT;
      default:          return 1'b0;
    endcase
  endfunction

  logic [5:0] dec_fetch, dec_op;
  assign dec_fetch = decode(instr[DATA_W+3:DATA_W], carry_n);
  assign dec_op    = decode(op, carry_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      op        <= OP_NOP;
      imm       <= '0;
      select    <= 2'b11;
      load_n    <= 4'b1111;
      carry_n   <= 1'b1;
      halted    <= 1'b0;
      fetch_req <= 1'b1;
    end else begin
      case (state)
        FETCH: if (fetch_ack) begin
          op        <= instr[DATA_W+3:DATA_W];
          imm       <= instr[DATA_W-1:0];
          // select is valid from DECODE onward, so it is decoded at fetch
          select    <= dec_fetch[1:0];
          fetch_req <= 1'b0;
          state     <= DECODE;
        end
        DECODE: begin
          load_n <= dec_op[5:2];
          state  <= EXEC;
        end
        EXEC: begin
          load_n <= 4'b1111;
          if (op == 4'b0000 || op == 4'b0101) carry_n <= ~alu_carry;
          else if (!is_nop(op))               carry_n <= 1'b1;
          if (EXT && op == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            fetch_req <= 1'b1;
            state     <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
